// File: rtl/scv_pkg.sv
// Shared identifiers for the cartridge loader path: probe FSM states and the
// ROM size exponent width consumed by the cartridge identification logic.
package scv_pkg;

    localparam int unsigned CART_SIZE_LOG2_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SIZE = 2'd2,
        DONE = 2'd3
    } cart_probe_state_t;

endpackage

// File: rtl/cart_probe.sv
// Watches the HPS ROM download stream and produces the cartridge size exponent
// (ceil(log2(bytes))) and a 32-bit byte-sum checksum for mapper selection.
module cart_probe
    import scv_pkg::*;
#(
    parameter int unsigned MAX_LOG2 = 24
) (
    input  logic                        CLK,
    input  logic                        RESB,
    input  logic                        DL_ACTIVE,
    input  logic                        DL_WR,
    input  logic [7:0]                  DL_DATA,
    output logic [CART_SIZE_LOG2_W-1:0] ROM_SIZE_LOG2,
    output logic [31:0]                 ROM_CKSUM,
    output logic                        ID_VALID,
    output logic                        BUSY
);

    localparam int unsigned CntW = MAX_LOG2 + 1;

    cart_probe_state_t             state_q, state_d;
    logic [CntW-1:0]               count_q, count_d;
    logic [31:0]                   sum_q, sum_d;
    logic [CART_SIZE_LOG2_W-1:0]   exp_q, exp_d;
    logic [CART_SIZE_LOG2_W-1:0]   size_q, size_d;
    logic [31:0]                   cksum_q, cksum_d;

    logic [CntW:0]   pow;
    logic            size_fits;
    logic [CntW-1:0] count_inc;
    logic [31:0]     wr_byte;

    // One extra bit so 1<<MAX_LOG2 never overflows against a saturated count.
    assign pow       = (CntW + 1)'(1) << exp_q;
    assign size_fits = (pow >= {1'b0, count_q}) ||
                       (exp_q == CART_SIZE_LOG2_W'(MAX_LOG2));
    assign count_inc = (count_q == {CntW{1'b1}}) ? count_q : count_q + CntW'(1);
    assign wr_byte   = {24'd0, DL_DATA};

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        sum_d   = sum_q;
        exp_d   = exp_q;
        size_d  = size_q;
        cksum_d = cksum_q;
        unique case (state_q)
            LOAD: begin
                if (DL_WR) begin
                    count_d = count_inc;
                    sum_d   = sum_q + wr_byte;
                end
                if (!DL_ACTIVE) begin
                    state_d = SIZE;
                    exp_d   = '0;
                end
            end
            IDLE, SIZE, DONE: begin
                if (DL_ACTIVE) begin
                    // A new download abandons any pending search; the entry byte counts.
                    state_d = LOAD;
                    count_d = DL_WR ? CntW'(1) : '0;
                    sum_d   = DL_WR ? wr_byte : '0;
                end else if (state_q == SIZE) begin
                    if (size_fits) begin
                        state_d = DONE;
                        size_d  = exp_q;
                        cksum_d = sum_q;
                    end else begin
                        exp_d = exp_q + CART_SIZE_LOG2_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESB) begin
        if (!RESB) begin
            state_q <= IDLE;
            count_q <= '0;
            sum_q   <= '0;
            exp_q   <= '0;
            size_q  <= '0;
            cksum_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            sum_q   <= sum_d;
            exp_q   <= exp_d;
            size_q  <= size_d;
            cksum_q <= cksum_d;
        end
    end

    assign ROM_SIZE_LOG2 = size_q;
    assign ROM_CKSUM     = cksum_q;
    assign ID_VALID      = (state_q == DONE);
    assign BUSY          = (state_q == LOAD) || (state_q == SIZE);

endmodule

// File: tb/tb_cart_probe.sv
// Self-checking bench for cart_probe: directed table rows, random loads against a
// byte-count/byte-sum reference model, reset and restart corner sequences.
module tb_cart_probe;

    localparam int unsigned MAX_LOG2 = 24;

    logic        CLK = 1'b0;
    logic        RESB;
    logic        DL_ACTIVE;
    logic        DL_WR;
    logic [7:0]  DL_DATA;
    logic [4:0]  ROM_SIZE_LOG2;
    logic [31:0] ROM_CKSUM;
    logic        ID_VALID;
    logic        BUSY;

    int vectors     = 0;
    int miscompares = 0;

    logic [4:0]  prev_log2;
    logic [31:0] prev_sum;
    bit          have_result;

    cart_probe #(.MAX_LOG2(MAX_LOG2)) dut (
        .CLK          (CLK),
        .RESB         (RESB),
        .DL_ACTIVE    (DL_ACTIVE),
        .DL_WR        (DL_WR),
        .DL_DATA      (DL_DATA),
        .ROM_SIZE_LOG2(ROM_SIZE_LOG2),
        .ROM_CKSUM    (ROM_CKSUM),
        .ID_VALID     (ID_VALID),
        .BUSY         (BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        int          nbytes;
        logic [7:0]  val;
        bit          amode;
        bit          last_on_fall;
        int          pad;
        logic [4:0]  exp_log2;
        logic [31:0] exp_sum;
        int          exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference exponent straight from the definition: ceil(log2(bytes)), capped.
    function automatic int ref_log2(input int cnt);
        int e;
        if (cnt <= 1) return 0;
        e = $clog2(cnt);
        if (e > int'(MAX_LOG2)) e = int'(MAX_LOG2);
        return e;
    endfunction

    // Drives one download and waits for ID_VALID; also accumulates the reference count/sum.
    task automatic do_load(input string name, input int n, input logic [7:0] val,
                           input bit amode, input bit last_on_fall, input int pad,
                           input int gap_pct, output int cnt, output logic [31:0] sum,
                           output int got_lat);
        int  written = 0;
        int  c       = 0;
        int  padleft = pad;
        bit  fell    = 0;
        cnt = 0;
        sum = '0;
        while (!fell) begin
            @(posedge CLK); #1;
            if (c == 1) begin
                check({name, " entry ID_VALID"}, 32'(ID_VALID), 32'd0);
                check({name, " entry BUSY"}, 32'(BUSY), 32'd1);
                check({name, " entry held size"}, 32'(ROM_SIZE_LOG2), 32'(prev_log2));
                check({name, " entry held cksum"}, ROM_CKSUM, prev_sum);
            end
            if (written < n) begin
                if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
                    DL_ACTIVE = 1'b1;
                    DL_WR     = 1'b0;
                end else begin
                    DL_WR   = 1'b1;
                    DL_DATA = amode ? written[7:0] : val;
                    sum     = sum + {24'd0, DL_DATA};
                    cnt++;
                    written++;
                    DL_ACTIVE = !(last_on_fall && written == n);
                    fell      = !DL_ACTIVE;
                end
            end else if (padleft > 0) begin
                DL_ACTIVE = 1'b1;
                DL_WR     = 1'b0;
                padleft--;
            end else begin
                DL_ACTIVE = 1'b0;
                DL_WR     = 1'b0;
                fell      = 1;
            end
            c++;
        end
        @(posedge CLK); #1;
        DL_WR   = 1'b0;
        got_lat = -1;
        for (int k = 1; k <= 64; k++) begin
            @(posedge CLK); #1;
            if (ID_VALID) begin
                got_lat = k;
                break;
            end
        end
    endtask

    task automatic check_result(input string name, input int got_lat, input logic [4:0] e_log2,
                                input logic [31:0] e_sum, input int e_lat);
        check({name, " latency"}, 32'(got_lat), 32'(e_lat));
        check({name, " ROM_SIZE_LOG2"}, 32'(ROM_SIZE_LOG2), 32'(e_log2));
        check({name, " ROM_CKSUM"}, ROM_CKSUM, e_sum);
        check({name, " BUSY at valid"}, 32'(BUSY), 32'd0);
        prev_log2   = e_log2;
        prev_sum    = e_sum;
        have_result = 1;
    endtask

    initial begin
        vec_t        tbl [8];
        int          cnt;
        int          lat;
        logic [31:0] sum;

        tbl[0] = '{"ff_8k_last_on_fall", 8192, 8'hFF, 1'b0, 1'b1, 0, 5'd13, 32'h001FE000, 14};
        tbl[1] = '{"x02_16k", 16384, 8'h02, 1'b0, 1'b0, 0, 5'd14, 32'h00008000, 15};
        tbl[2] = '{"addr_32k", 32768, 8'h00, 1'b1, 1'b0, 0, 5'd15, 32'h003FC000, 16};
        tbl[3] = '{"x01_20k", 20000, 8'h01, 1'b0, 1'b0, 0, 5'd15, 32'h00004E20, 16};
        tbl[4] = '{"empty_3cyc", 0, 8'h00, 1'b0, 1'b0, 3, 5'd0, 32'h0, 1};
        tbl[5] = '{"one_byte", 1, 8'h5A, 1'b0, 1'b0, 0, 5'd0, 32'h5A, 1};
        tbl[6] = '{"two_bytes", 2, 8'h10, 1'b0, 1'b0, 0, 5'd1, 32'h20, 2};
        tbl[7] = '{"three_bytes", 3, 8'h80, 1'b0, 1'b0, 0, 5'd2, 32'h180, 3};

        RESB        = 1'b0;
        DL_ACTIVE   = 1'b0;
        DL_WR       = 1'b0;
        DL_DATA     = '0;
        prev_log2   = '0;
        prev_sum    = '0;
        have_result = 0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset ID_VALID", 32'(ID_VALID), 32'd0);
        check("reset BUSY", 32'(BUSY), 32'd0);
        check("reset ROM_SIZE_LOG2", 32'(ROM_SIZE_LOG2), 32'd0);
        check("reset ROM_CKSUM", ROM_CKSUM, 32'd0);
        #2 RESB = 1'b1;

        // Random downloads with write gaps; stray writes between downloads must be ignored.
        for (int r = 0; r < 6; r++) begin
            int          n;
            int          pad;
            bit          lof;
            logic [7:0]  v;
            bit          am;
            for (int j = 0; j < int'($urandom_range(2, 6)); j++) begin
                @(posedge CLK); #1;
                DL_ACTIVE = 1'b0;
                DL_WR     = 1'($urandom_range(1));
                DL_DATA   = 8'($urandom);
            end
            @(posedge CLK); #1;
            DL_WR = 1'b0;
            check("idle ID_VALID", 32'(ID_VALID), 32'(have_result));
            check("idle held size", 32'(ROM_SIZE_LOG2), 32'(prev_log2));
            check("idle held cksum", ROM_CKSUM, prev_sum);
            n   = int'($urandom_range(0, 400));
            v   = 8'($urandom);
            am  = 1'($urandom_range(1));
            lof = (n >= 2) && ($urandom_range(1) == 1);
            pad = (n == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 2));
            do_load("rand", n, v, am, lof, pad, 25, cnt, sum, lat);
            check_result("rand", lat, 5'(ref_log2(cnt)), sum, ref_log2(cnt) + 1);
        end

        // Reset in the middle of a download clears everything asynchronously.
        for (int i = 0; i < 100; i++) begin
            @(posedge CLK); #1;
            DL_ACTIVE = 1'b1;
            DL_WR     = 1'b1;
            DL_DATA   = 8'hA5;
        end
        #2 RESB = 1'b0;
        #1;
        check("midreset ID_VALID", 32'(ID_VALID), 32'd0);
        check("midreset BUSY", 32'(BUSY), 32'd0);
        check("midreset ROM_SIZE_LOG2", 32'(ROM_SIZE_LOG2), 32'd0);
        check("midreset ROM_CKSUM", ROM_CKSUM, 32'd0);
        DL_ACTIVE = 1'b0;
        DL_WR     = 1'b0;
        @(posedge CLK);
        #2 RESB = 1'b1;
        prev_log2   = '0;
        prev_sum    = '0;
        have_result = 0;

        foreach (tbl[i]) begin
            do_load(tbl[i].name, tbl[i].nbytes, tbl[i].val, tbl[i].amode, tbl[i].last_on_fall,
                    tbl[i].pad, 0, cnt, sum, lat);
            check_result(tbl[i].name, lat, tbl[i].exp_log2, tbl[i].exp_sum, tbl[i].exp_lat);
        end

        // Restart while the exponent search is still running: old outputs stay, new load wins.
        for (int i = 0; i < 1000; i++) begin
            @(posedge CLK); #1;
            DL_ACTIVE = 1'b1;
            DL_WR     = 1'b1;
            DL_DATA   = 8'h11;
        end
        @(posedge CLK); #1;
        DL_ACTIVE = 1'b0;
        DL_WR     = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        check("size phase ID_VALID", 32'(ID_VALID), 32'd0);
        check("size phase BUSY", 32'(BUSY), 32'd1);
        DL_ACTIVE = 1'b1;
        @(posedge CLK); #1;
        check("restart ID_VALID", 32'(ID_VALID), 32'd0);
        check("restart held size", 32'(ROM_SIZE_LOG2), 32'(prev_log2));
        check("restart held cksum", ROM_CKSUM, prev_sum);
        do_load("after_restart", 5, 8'h07, 1'b0, 1'b0, 0, 0, cnt, sum, lat);
        check_result("after_restart", lat, 5'd3, 32'h23, 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
